// File: rtl/piece_drop_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : piece_drop_controller_if
// Brief    : Move-command handshake plus board-occupancy read port.
// Revision : 1.0 - initial release
// ============================================================================
interface piece_drop_controller_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       board_rd_req;
  logic [3:0] board_rd_col;
  logic [4:0] board_rd_row;
  logic       board_rd_gnt;
  logic       board_rd_occ;

  modport master (
    input  cmd_valid, cmd, board_rd_gnt, board_rd_occ,
    output cmd_ready, board_rd_req, board_rd_col, board_rd_row
  );

  modport slave (
    output cmd_valid, cmd, board_rd_gnt, board_rd_occ,
    input  cmd_ready, board_rd_req, board_rd_col, board_rd_row
  );
endinterface
`default_nettype wire

// File: rtl/piece_drop_controller.sv
`default_nettype none
// ============================================================================
// Module   : piece_drop_controller
// Brief    : Falling-piece position sequencer with serial collision checks.
// Options  : LOCK_DELAY_EN - a tick/soft-down landing arms instead of locking.
// Revision : 1.0 - initial release
// ============================================================================
module piece_drop_controller #(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int CELL      = 20,
  parameter int X0        = 240,
  parameter int Y0        = 60,
  parameter int SPAWN_COL = 4
) (
  input  wire                   clk,
  input  wire                   reset,
  input  wire                   start,
  input  wire                   tick,
  input  wire  [15:0]           shape_off,
  piece_drop_controller_if.master bus,
  output logic [3:0]            piece_col,
  output logic [4:0]            piece_row,
  output logic [9:0]            sq_x,
  output logic [9:0]            sq_y,
  output logic                  lock_pulse,
  output logic                  game_over,
  output logic                  busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SPAWN     = 3'd1;
  localparam logic [2:0] ST_WAIT      = 3'd2;
  localparam logic [2:0] ST_CHECK     = 3'd3;
  localparam logic [2:0] ST_COMMIT    = 3'd4;
  localparam logic [2:0] ST_LOCK      = 3'd5;
  localparam logic [2:0] ST_GAME_OVER = 3'd6;

  localparam logic [1:0] K_SPAWN = 2'd0;
  localparam logic [1:0] K_SHIFT = 2'd1;
  localparam logic [1:0] K_DOWN  = 2'd2;
  localparam logic [1:0] K_HARD  = 2'd3;

  localparam logic [1:0] CMD_LEFT  = 2'd0;
  localparam logic [1:0] CMD_RIGHT = 2'd1;
  localparam logic [1:0] CMD_SOFT  = 2'd2;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [15:0] r_shape;
  logic [4:0]  r_cand_col;
  logic [4:0]  r_cand_row;
  logic [1:0]  r_kind;
  logic [1:0]  r_cell;
  logic        r_phase;
  logic        r_pending;
  logic [3:0]  r_col;
  logic [4:0]  r_row;
`ifdef LOCK_DELAY_EN
  logic        r_armed;
`endif

  logic [3:0]  w_off;
  logic [5:0]  w_cell_col;
  logic [5:0]  w_cell_row;
  logic        w_cell_oob;
  logic        w_hit;
  logic        w_free_all;
  logic        w_go_down;
  logic        w_accept;

  // Candidate column is one bit wider so that left-of-zero becomes 31, which
  // lands out of bounds instead of wrapping onto the right edge.
  assign w_off      = r_shape[{r_cell, 2'b00} +: 4];
  assign w_cell_col = {1'b0, r_cand_col} + {4'b0000, w_off[3:2]};
  assign w_cell_row = {1'b0, r_cand_row} + {4'b0000, w_off[1:0]};
  assign w_cell_oob = (w_cell_col >= 6'(COLS)) || (w_cell_row >= 6'(ROWS));

  assign w_hit      = (r_state == ST_CHECK) && (r_phase ? bus.board_rd_occ : w_cell_oob);
  assign w_free_all = (r_state == ST_CHECK) && r_phase && !bus.board_rd_occ && (r_cell == 2'd3);
  assign w_go_down  = (r_state == ST_WAIT) && (tick || r_pending);
  assign w_accept   = (r_state == ST_WAIT) && !tick && !r_pending && bus.cmd_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SPAWN;
        end
      end
      ST_SPAWN: w_state_nxt = ST_CHECK;
      ST_WAIT: begin
        if (w_go_down || w_accept) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_hit) begin
          case (r_kind)
            K_SPAWN: w_state_nxt = ST_GAME_OVER;
            K_SHIFT: w_state_nxt = ST_WAIT;
`ifdef LOCK_DELAY_EN
            K_DOWN:  w_state_nxt = r_armed ? ST_LOCK : ST_WAIT;
`else
            K_DOWN:  w_state_nxt = ST_LOCK;
`endif
            default: w_state_nxt = ST_LOCK;
          endcase
        end else if (w_free_all) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT:    w_state_nxt = (r_kind == K_HARD) ? ST_CHECK : ST_WAIT;
      ST_LOCK:      w_state_nxt = ST_SPAWN;
      ST_GAME_OVER: w_state_nxt = ST_GAME_OVER;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready    = (r_state == ST_WAIT) && !tick && !r_pending;
    bus.board_rd_req = (r_state == ST_CHECK) && !r_phase && !w_cell_oob;
    bus.board_rd_col = w_cell_col[3:0];
    bus.board_rd_row = w_cell_row[4:0];
    lock_pulse       = (r_state == ST_LOCK);
    game_over        = (r_state == ST_GAME_OVER);
    busy             = (r_state != ST_IDLE) && (r_state != ST_WAIT) &&
                       (r_state != ST_GAME_OVER);
    piece_col        = r_col;
    piece_row        = r_row;
    sq_x             = 10'(X0) + 10'(CELL) * {6'd0, r_col};
    sq_y             = 10'(Y0) + 10'(CELL) * {5'd0, r_row};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shape    <= 16'd0;
      r_cand_col <= 5'd0;
      r_cand_row <= 5'd0;
      r_kind     <= K_SPAWN;
      r_cell     <= 2'd0;
      r_phase    <= 1'b0;
      r_col      <= 4'd0;
      r_row      <= 5'd0;
    end else begin
      case (r_state)
        ST_SPAWN: begin
          r_shape    <= shape_off;
          r_cand_col <= 5'(SPAWN_COL);
          r_cand_row <= 5'd0;
          r_kind     <= K_SPAWN;
          r_cell     <= 2'd0;
          r_phase    <= 1'b0;
        end
        ST_WAIT: begin
          r_cell  <= 2'd0;
          r_phase <= 1'b0;
          if (w_go_down) begin
            r_cand_col <= {1'b0, r_col};
            r_cand_row <= r_row + 5'd1;
            r_kind     <= K_DOWN;
          end else if (w_accept) begin
            case (bus.cmd)
              CMD_LEFT: begin
                r_cand_col <= {1'b0, r_col} - 5'd1;
                r_cand_row <= r_row;
                r_kind     <= K_SHIFT;
              end
              CMD_RIGHT: begin
                r_cand_col <= {1'b0, r_col} + 5'd1;
                r_cand_row <= r_row;
                r_kind     <= K_SHIFT;
              end
              CMD_SOFT: begin
                r_cand_col <= {1'b0, r_col};
                r_cand_row <= r_row + 5'd1;
                r_kind     <= K_DOWN;
              end
              default: begin
                r_cand_col <= {1'b0, r_col};
                r_cand_row <= r_row + 5'd1;
                r_kind     <= K_HARD;
              end
            endcase
          end
        end
        ST_CHECK: begin
          // Address phase waits for grant; data phase moves to the next cell.
          if (!r_phase) begin
            if (!w_cell_oob && bus.board_rd_gnt) begin
              r_phase <= 1'b1;
            end
          end else begin
            r_phase <= 1'b0;
            r_cell  <= r_cell + 2'd1;
          end
        end
        ST_COMMIT: begin
          r_col   <= r_cand_col[3:0];
          r_row   <= r_cand_row;
          r_cell  <= 2'd0;
          r_phase <= 1'b0;
          if (r_kind == K_HARD) begin
            r_cand_row <= r_cand_row + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // One-deep gravity memory; IDLE and GAME_OVER have no live piece to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_state == ST_LOCK) begin
      r_pending <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      r_pending <= 1'b0;
    end else if (tick && (r_state != ST_IDLE) && (r_state != ST_GAME_OVER)) begin
      r_pending <= 1'b1;
    end
  end

`ifdef LOCK_DELAY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (r_state == ST_SPAWN) begin
      r_armed <= 1'b0;
    end else if (w_hit && (r_kind == K_DOWN)) begin
      r_armed <= 1'b1;
    end else if ((r_state == ST_COMMIT) && (r_kind == K_DOWN)) begin
      r_armed <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_piece_drop_controller.sv
`default_nettype none
// Self-checking bench for piece_drop_controller: directed steps plus
// randomized moves compared against a board-level placement model.
module tb_piece_drop_controller;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int SPAWN_COL = 4;
  localparam int LIMIT = 1500;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        tick;
  logic [15:0] shape_off;
  logic [3:0]  piece_col;
  logic [4:0]  piece_row;
  logic [9:0]  sq_x;
  logic [9:0]  sq_y;
  logic        lock_pulse;
  logic        game_over;
  logic        busy;

  piece_drop_controller_if bus ();

  piece_drop_controller dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .shape_off  (shape_off),
    .bus        (bus),
    .piece_col  (piece_col),
    .piece_row  (piece_row),
    .sq_x       (sq_x),
    .sq_y       (sq_y),
    .lock_pulse (lock_pulse),
    .game_over  (game_over),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  bit   board [ROWS][COLS];
  logic gnt_block = 1'b0;
  logic gnt_rand  = 1'b0;
  logic rd_valid  = 1'b0;
  logic rd_occ    = 1'b0;
  int   reads     = 0;
  int   lock_cnt  = 0;
  int   lock_row  = -1;
  int   lock_col  = -1;
  int   last_rd_col = -1;

  // Board memory: captures granted addresses mid-cycle, answers next cycle.
  always @(negedge clk) begin
    if (bus.board_rd_req === 1'b1 && bus.board_rd_gnt === 1'b1) begin
      reads++;
      last_rd_col = int'(bus.board_rd_col);
      rd_valid = 1'b1;
      if (int'(bus.board_rd_col) < COLS && int'(bus.board_rd_row) < ROWS)
        rd_occ = board[int'(bus.board_rd_row)][int'(bus.board_rd_col)];
      else
        rd_occ = 1'b1;
    end else begin
      rd_valid = 1'b0;
    end
    if (lock_pulse === 1'b1) begin
      lock_cnt++;
      lock_row = int'(piece_row);
      lock_col = int'(piece_col);
    end
  end

  always @(posedge clk) begin
    #1;
    bus.board_rd_occ = rd_valid ? rd_occ : 1'($urandom_range(0, 1));
    bus.board_rd_gnt = gnt_block ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_settle(input string tag);
    int n;
    n = 0;
    while (!(bus.cmd_ready === 1'b1 || game_over === 1'b1) && n < LIMIT) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < LIMIT), 32'd1);
  endtask

  // Placement model working directly on cell coordinates.
  int m_col, m_row, m_locks;
  bit m_over;
  int sdx [4];
  int sdy [4];

  function automatic void set_shape(input logic [15:0] s);
    for (int k = 0; k < 4; k++) begin
      sdx[k] = int'(s[4*k+2 +: 2]);
      sdy[k] = int'(s[4*k +: 2]);
    end
  endfunction

  function automatic bit fits(input int c, input int r);
    if (c < 0) return 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (c + sdx[k] >= COLS || r + sdy[k] >= ROWS) return 1'b0;
      if (board[r + sdy[k]][c + sdx[k]]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void land();
    m_locks++;
    m_col = SPAWN_COL;
    m_row = 0;
    if (!fits(SPAWN_COL, 0)) m_over = 1'b1;
  endfunction

  function automatic void model_op(input int op);
    case (op)
      0: if (fits(m_col - 1, m_row)) m_col--;
      1: if (fits(m_col + 1, m_row)) m_col++;
      3: begin
        while (fits(m_col, m_row + 1)) m_row++;
        land();
      end
      default: if (fits(m_col, m_row + 1)) m_row++; else land();
    endcase
  endfunction

  // op: 0 left, 1 right, 2 soft down, 3 hard drop, 4 gravity tick
  task automatic do_op(input int op, input string tag);
    int locks0;
    locks0 = lock_cnt;
    if (op == 4) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end else begin
      bus.cmd_valid = 1'b1;
      bus.cmd = 2'(op);
      step();
      bus.cmd_valid = 1'b0;
    end
    wait_settle(tag);
    model_op(op);
    check({tag, "_col"}, 32'(piece_col), 32'(m_col));
    check({tag, "_row"}, 32'(piece_row), 32'(m_row));
    check({tag, "_locks"}, 32'(lock_cnt - locks0), 32'(m_locks));
    check({tag, "_over"}, 32'(game_over), 32'(m_over));
    m_locks = 0;
  endtask

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = 1'b0;
  endtask

  initial begin
    int reads0;
    int row0;
    int col0;
    int op;
    reset = 1'b1;
    start = 1'b0;
    tick = 1'b0;
    shape_off = 16'h0000;
    bus.cmd_valid = 1'b0;
    bus.cmd = 2'd0;
    m_locks = 0;
    m_over = 1'b0;
    clear_board();
    repeat (3) step();
    reset = 1'b0;
    step();

    check("rst_col", 32'(piece_col), 32'd0);
    check("rst_row", 32'(piece_row), 32'd0);
    check("rst_sq_x", 32'(sq_x), 32'd240);
    check("rst_sq_y", 32'(sq_y), 32'd60);
    check("rst_req", 32'(bus.board_rd_req), 32'd0);
    check("rst_lock", 32'(lock_pulse), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single-cell piece spawn on an empty board.
    set_shape(shape_off);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_settle("spawn");
    m_col = SPAWN_COL;
    m_row = 0;
    check("spawn_col", 32'(piece_col), 32'd4);
    check("spawn_row", 32'(piece_row), 32'd0);
    check("spawn_sq_x", 32'(sq_x), 32'd320);
    check("spawn_sq_y", 32'(sq_y), 32'd60);
    check("spawn_busy", 32'(busy), 32'd0);

    // Left move latency: old position through cycle 9, new in cycle 10.
    reads0 = reads;
    bus.cmd_valid = 1'b1;
    bus.cmd = 2'd0;
    step();
    bus.cmd_valid = 1'b0;
    check("lat_busy", 32'(busy), 32'd1);
    repeat (8) step();
    check("lat_c9_col", 32'(piece_col), 32'd4);
    step();
    check("lat_c10_col", 32'(piece_col), 32'd3);
    check("lat_c10_sq_x", 32'(sq_x), 32'd300);
    check("lat_reads", 32'(reads - reads0), 32'd4);
    check("lat_rd_col", 32'(last_rd_col), 32'd3);
    wait_settle("lat");
    m_col = 3;

    // Walk to column 0, then a left there is out of bounds with no read.
    do_op(0, "left_a");
    do_op(0, "left_b");
    do_op(0, "left_c");
    reads0 = reads;
    do_op(0, "left_edge");
    check("left_edge_reads", 32'(reads - reads0), 32'd0);
    check("left_edge_ready", 32'(bus.cmd_ready), 32'd1);

    // Hard drop on an empty board locks on the bottom row, then respawns.
    do_op(3, "hard");
    check("hard_lock_row", 32'(lock_row), 32'd19);
    check("hard_lock_col", 32'(lock_col), 32'd0);

    // Grant withheld for five cycles while a second tick arrives.
    row0 = int'(piece_row);
    col0 = int'(piece_col);
    gnt_block = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 32'(bus.board_rd_req), 32'd1);
      check("stall_row", 32'(bus.board_rd_row), 32'(row0 + 1));
      check("stall_col", 32'(bus.board_rd_col), 32'(col0));
      if (i == 4) gnt_block = 1'b0;
      if (i == 1) tick = 1'b1;
      step();
      tick = 1'b0;
    end
    wait_settle("stall");
    model_op(4);
    model_op(4);
    check("stall_row_final", 32'(piece_row), 32'(m_row));
    check("stall_col_final", 32'(piece_col), 32'(m_col));

    // Reset while a check is in flight.
    bus.cmd_valid = 1'b1;
    bus.cmd = 2'd2;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    check("midrst_req_before", 32'(bus.board_rd_req), 32'd1);
    reset = 1'b1;
    step();
    check("midrst_req", 32'(bus.board_rd_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_row", 32'(piece_row), 32'd0);
    reset = 1'b0;
    step();

    // Blocked spawn cell ends the game; everything but reset is ignored.
    board[0][SPAWN_COL] = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_settle("gover");
    check("gover_flag", 32'(game_over), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick = 1'(i % 2);
      start = 1'(i % 3 == 0);
      bus.cmd_valid = 1'b1;
      bus.cmd = 2'(i);
      step();
    end
    tick = 1'b0;
    start = 1'b0;
    bus.cmd_valid = 1'b0;
    check("gover_sticky", 32'(game_over), 32'd1);
    check("gover_ready", 32'(bus.cmd_ready), 32'd0);
    check("gover_req", 32'(bus.board_rd_req), 32'd0);
    check("gover_busy", 32'(busy), 32'd0);
    check("gover_col", 32'(piece_col), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("gover_cleared", 32'(game_over), 32'd0);

    // Randomized play: sparse board, random shape, jittery grant.
    clear_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = ($urandom_range(0, 99) < 15);
    shape_off = 16'($urandom());
    set_shape(shape_off);
    for (int k = 0; k < 4; k++) board[sdy[k]][SPAWN_COL + sdx[k]] = 1'b0;
    gnt_rand = 1'b1;
    m_locks = 0;
    m_over = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_settle("rnd_spawn");
    m_col = SPAWN_COL;
    m_row = 0;
    check("rnd_spawn_col", 32'(piece_col), 32'(m_col));
    check("rnd_spawn_row", 32'(piece_row), 32'(m_row));
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 19));
      if (op < 5) op = 0;
      else if (op < 10) op = 1;
      else if (op < 14) op = 2;
      else if (op < 18) op = 4;
      else op = 3;
      do_op(op, "rnd");
      check("rnd_sq_x", 32'(sq_x), 32'(240 + 20 * m_col));
      check("rnd_sq_y", 32'(sq_y), 32'(60 + 20 * m_row));
    end
    gnt_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
